// File: rtl/fadd_rr_sched.sv
// Round-robin scheduler sharing one fixed-latency pipelined FP adder among NREQ requesters.
// Results are routed back by a tag pipe aligned with the adder; per-requester in-flight limit.

module fadd_rr_cnt #(
    parameter int CW     = 2,
    parameter int MAXOUT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic avail
);
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && !dec) begin
            cnt <= cnt + CW'(1);
        end else if (dec && !inc && cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign avail = (cnt < CW'(MAXOUT));
endmodule

module fadd_rr_sched #(
    parameter int N      = 32,
    parameter int E      = 8,
    parameter int S      = 1,
    parameter int NREQ   = 4,
    parameter int LAT    = 3,
    parameter int MAXOUT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_op1,
    input  logic [NREQ*N-1:0] req_op2,
    output logic              fadd_en,
    output logic [N-1:0]      fadd_op1,
    output logic [N-1:0]      fadd_op2,
    input  logic              fadd_res_val,
    input  logic [N-1:0]      fadd_res,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [N-1:0]      rsp_data,
    output logic              busy,
    output logic              err
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(MAXOUT + 1);
    localparam logic [PW:0] NREQ_P = (PW + 1)'(NREQ);
    // Format widths belong to the adder instance; kept only for parameter compatibility.
    localparam int fmt_unused = E + S;

    logic [NREQ-1:0][N-1:0]  op1_arr, op2_arr;
    logic [NREQ-1:0]         avail, grant, tail_oh;
    logic [PW-1:0]           ptr, gnt_id;
    logic [PW:0]             idx;
    logic                    accept;
    // Stage 0 is the issue register (its valid bit is fadd_en); stage LAT lines up with fadd_res_val.
    logic [LAT:0]            vld_pipe;
    logic [LAT:0][PW-1:0]    id_pipe;

    assign op1_arr = req_op1;
    assign op2_arr = req_op2;

    always_comb begin
        grant  = '0;
        gnt_id = '0;
        idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr} + (PW + 1)'(k);
            if (idx >= NREQ_P) idx = idx - NREQ_P;
            if (grant == '0 && !rst && req_valid[idx[PW-1:0]] && avail[idx[PW-1:0]]) begin
                grant[idx[PW-1:0]] = 1'b1;
                gnt_id             = idx[PW-1:0];
            end
        end
    end

    assign req_ready = grant;
    assign accept    = |grant;

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        fadd_rr_cnt #(.CW(CW), .MAXOUT(MAXOUT)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (grant[i]),
            .dec   (rsp_valid[i]),
            .avail (avail[i])
        );
    end

    always_comb begin
        tail_oh              = '0;
        tail_oh[id_pipe[LAT]] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            vld_pipe  <= '0;
            id_pipe   <= '0;
            fadd_op1  <= '0;
            fadd_op2  <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            err       <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[LAT-1:0], accept};
            id_pipe  <= {id_pipe[LAT-1:0], gnt_id};
            if (accept) begin
                ptr      <= (gnt_id == PW'(NREQ - 1)) ? '0 : gnt_id + PW'(1);
                fadd_op1 <= op1_arr[gnt_id];
                fadd_op2 <= op2_arr[gnt_id];
            end
            // Untagged results are dropped so no counter is decremented for them.
            if (fadd_res_val && vld_pipe[LAT]) begin
                rsp_valid <= tail_oh;
                rsp_data  <= fadd_res;
            end else begin
                rsp_valid <= '0;
            end
            if (fadd_res_val != vld_pipe[LAT]) err <= 1'b1;
        end
    end

    assign fadd_en = vld_pipe[0];
    assign busy    = (|vld_pipe) || (|rsp_valid);
endmodule
